// File: rtl/bp_pkg.sv
// Shared branch-prediction definitions: 2-bit direction counter encoding,
// the saturating counter update, and the fetch reset vector.
package bp_pkg;

  // Direction counter encoding; bit[1] is the taken prediction.
  localparam logic [1:0] CTR_SNT = 2'b00;  // strong not-taken
  localparam logic [1:0] CTR_WNT = 2'b01;  // weak not-taken
  localparam logic [1:0] CTR_WT  = 2'b10;  // weak taken
  localparam logic [1:0] CTR_ST  = 2'b11;  // strong taken

  // Freshly allocated entries start weakly taken.
  localparam logic [1:0] CTR_ALLOC = CTR_WT;

  // Fetch reset vector, shared with the fetch stage.
  localparam logic [31:0] RESET_PC = 32'h0001_0000;

  // Saturating up/down update of a direction counter.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == CTR_ST) ? CTR_ST : ctr + 2'b01;
    end else begin
      return (ctr == CTR_SNT) ? CTR_SNT : ctr - 2'b01;
    end
  endfunction

endpackage

// File: rtl/btb_array.sv
// BTB storage: valid, tag, target and counter per entry.
// One combinational lookup read port and one synchronous write port. The
// write port also exposes the entry it addresses so the trainer can do a
// read-modify-write of the counter in a single cycle.
module btb_array
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int INDEX_W = $clog2(ENTRIES),
  parameter int TAG_W   = 32 - INDEX_W - 2
) (
  input  logic               clk,
  input  logic               rst,
  // lookup read port
  input  logic [INDEX_W-1:0] rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [31:0]        rd_target,
  output logic [1:0]         rd_ctr,
  // write port (plus current contents of the addressed entry)
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [31:0]        wr_target,
  input  logic [1:0]         wr_ctr,
  output logic               wr_cur_valid,
  output logic [TAG_W-1:0]   wr_cur_tag,
  output logic [31:0]        wr_cur_target,
  output logic [1:0]         wr_cur_ctr
);

  logic               valid_reg  [ENTRIES];
  logic [TAG_W-1:0]   tag_reg    [ENTRIES];
  logic [31:0]        target_reg [ENTRIES];
  logic [1:0]         ctr_reg    [ENTRIES];

  // Asynchronous reads: lookup must resolve in the same cycle.
  assign rd_valid      = valid_reg[rd_idx];
  assign rd_tag        = tag_reg[rd_idx];
  assign rd_target     = target_reg[rd_idx];
  assign rd_ctr        = ctr_reg[rd_idx];
  assign wr_cur_valid  = valid_reg[wr_idx];
  assign wr_cur_tag    = tag_reg[wr_idx];
  assign wr_cur_target = target_reg[wr_idx];
  assign wr_cur_ctr    = ctr_reg[wr_idx];

  // Entry storage: reset invalidates everything; every write leaves the entry valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_reg[i]  <= 1'b0;
        tag_reg[i]    <= '0;
        target_reg[i] <= '0;
        ctr_reg[i]    <= CTR_WNT;
      end
    end else if (wr_en) begin
      valid_reg[wr_idx]  <= 1'b1;
      tag_reg[wr_idx]    <= wr_tag;
      target_reg[wr_idx] <= wr_target;
      ctr_reg[wr_idx]    <= wr_ctr;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters, beside the fetch stage.
// Zero-latency lookup, one training write per cycle from execute, and
// free-running hit / mispredict performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int INDEX_W = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] lookup_PC,
  output logic        BTB_hit,
  output logic        is_branch_predict,
  output logic [31:0] BTB_PC,
  input  logic        update_valid,
  input  logic [31:0] update_PC,
  input  logic        update_taken,
  input  logic [31:0] update_target,
  input  logic        update_mispredict,
  output logic [31:0] hit_count,
  output logic [31:0] mispredict_count
);

  localparam int TAG_W = 32 - INDEX_W - 2;

  logic [INDEX_W-1:0] lookup_idx;
  logic [TAG_W-1:0]   lookup_tag;
  logic [INDEX_W-1:0] upd_idx;
  logic [TAG_W-1:0]   upd_tag;

  logic               rd_valid;
  logic [TAG_W-1:0]   rd_tag;
  logic [31:0]        rd_target;
  logic [1:0]         rd_ctr;

  logic               wr_en;
  logic [31:0]        wr_target;
  logic [1:0]         wr_ctr;
  logic               cur_valid;
  logic [TAG_W-1:0]   cur_tag;
  logic [31:0]        cur_target;
  logic [1:0]         cur_ctr;
  logic               upd_match;

  logic [31:0]        hit_count_reg;
  logic [31:0]        mispredict_count_reg;

  // Instructions are word aligned, so the byte offset carries no information.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_PC[1:0], update_PC[1:0]};

  assign lookup_idx = lookup_PC[INDEX_W+1:2];
  assign lookup_tag = lookup_PC[31:INDEX_W+2];
  assign upd_idx    = update_PC[INDEX_W+1:2];
  assign upd_tag    = update_PC[31:INDEX_W+2];

  btb_array #(
    .ENTRIES (ENTRIES),
    .INDEX_W (INDEX_W),
    .TAG_W   (TAG_W)
  ) u_array (
    .clk           (clk),
    .rst           (rst),
    .rd_idx        (lookup_idx),
    .rd_valid      (rd_valid),
    .rd_tag        (rd_tag),
    .rd_target     (rd_target),
    .rd_ctr        (rd_ctr),
    .wr_en         (wr_en),
    .wr_idx        (upd_idx),
    .wr_tag        (upd_tag),
    .wr_target     (wr_target),
    .wr_ctr        (wr_ctr),
    .wr_cur_valid  (cur_valid),
    .wr_cur_tag    (cur_tag),
    .wr_cur_target (cur_target),
    .wr_cur_ctr    (cur_ctr)
  );

  // Lookup: hit compare and prediction, no bypass from a same-cycle update.
  always_comb begin
    BTB_hit           = rd_valid && (rd_tag == lookup_tag);
    is_branch_predict = BTB_hit && rd_ctr[1];
    BTB_PC            = BTB_hit ? rd_target : 32'h0;
  end

  // Training: train a matching entry, allocate on taken miss, ignore not-taken miss.
  always_comb begin
    upd_match = cur_valid && (cur_tag == upd_tag);
    wr_en     = 1'b0;
    wr_ctr    = CTR_ALLOC;
    wr_target = update_target;
    if (update_valid) begin
      if (upd_match) begin
        wr_en     = 1'b1;
        wr_ctr    = ctr_next(cur_ctr, update_taken);
        wr_target = update_taken ? update_target : cur_target;
      end else if (update_taken) begin
        wr_en = 1'b1;
      end
    end
  end

  // Performance counters, wrapping naturally at 32 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hit_count_reg        <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (BTB_hit) begin
        hit_count_reg <= hit_count_reg + 32'd1;
      end
      if (update_valid && update_mispredict) begin
        mispredict_count_reg <= mispredict_count_reg + 32'd1;
      end
    end
  end

  assign hit_count        = hit_count_reg;
  assign mispredict_count = mispredict_count_reg;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed self-checking bench for branch_predictor (ENTRIES=64).
// Inputs change just after the falling edge; outputs are checked 1ns later.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] lookup_PC = 32'h0;
  logic        BTB_hit;
  logic        is_branch_predict;
  logic [31:0] BTB_PC;
  logic        update_valid = 1'b0;
  logic [31:0] update_PC = 32'h0;
  logic        update_taken = 1'b0;
  logic [31:0] update_target = 32'h0;
  logic        update_mispredict = 1'b0;
  logic [31:0] hit_count;
  logic [31:0] mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] IDLE = 32'h0001_0000;  // never allocated, always misses

  branch_predictor #(.ENTRIES(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .lookup_PC         (lookup_PC),
    .BTB_hit           (BTB_hit),
    .is_branch_predict (is_branch_predict),
    .BTB_PC            (BTB_PC),
    .update_valid      (update_valid),
    .update_PC         (update_PC),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .hit_count         (hit_count),
    .mispredict_count  (mispredict_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle of stimulus: drive after the falling edge, settle 1ns.
  task automatic drive(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic umis);
    @(negedge clk);
    lookup_PC         = lpc;
    update_valid      = uv;
    update_PC         = upc;
    update_taken      = ut;
    update_target     = utgt;
    update_mispredict = umis;
    #1;
    $display("t=%0t lookup=%h upd_v=%0b upd_pc=%h taken=%0b tgt=%h mis=%0b | hit=%0b pred=%0b btb_pc=%h hits=%0d mis=%0d",
             $time, lpc, uv, upc, ut, utgt, umis, BTB_hit, is_branch_predict, BTB_PC,
             hit_count, mispredict_count);
  endtask

  initial begin
    // 1. Reset
    repeat (3) @(negedge clk);
    rst       = 1'b1;
    lookup_PC = IDLE;
    #1;
    chk("reset_hit", {31'b0, BTB_hit}, 32'd0);
    chk("reset_pred", {31'b0, is_branch_predict}, 32'd0);
    chk("reset_btb_pc", BTB_PC, 32'h0);
    chk("reset_hit_count", hit_count, 32'd0);
    chk("reset_mis_count", mispredict_count, 32'd0);

    // 2. Allocate 0x10040 -> 0x10100
    drive(IDLE, 1'b1, 32'h0001_0040, 1'b1, 32'h0001_0100, 1'b0);
    chk("alloc_idle_miss", {31'b0, BTB_hit}, 32'd0);
    drive(32'h0001_0040, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("alloc_hit", {31'b0, BTB_hit}, 32'd1);
    chk("alloc_pred", {31'b0, is_branch_predict}, 32'd1);
    chk("alloc_target", BTB_PC, 32'h0001_0100);

    // 3. Two taken (10->11->11), then two not-taken (11->10->01)
    drive(IDLE, 1'b1, 32'h0001_0040, 1'b1, 32'h0001_0100, 1'b0);
    drive(IDLE, 1'b1, 32'h0001_0040, 1'b1, 32'h0001_0100, 1'b0);
    // lookup sees pre-update strong-taken counter
    drive(32'h0001_0040, 1'b1, 32'h0001_0040, 1'b0, 32'hDEAD_BEEF, 1'b0);
    chk("sat_pred_taken", {31'b0, is_branch_predict}, 32'd1);
    drive(IDLE, 1'b1, 32'h0001_0040, 1'b0, 32'hDEAD_BEEF, 1'b0);
    drive(32'h0001_0040, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("train_hit", {31'b0, BTB_hit}, 32'd1);
    chk("train_pred_nt", {31'b0, is_branch_predict}, 32'd0);
    chk("train_target_kept", BTB_PC, 32'h0001_0100);
    chk("train_hit_count", hit_count, 32'd2);

    // 4. Alias replace at index 0x10
    drive(IDLE, 1'b1, 32'h0001_0140, 1'b1, 32'h0001_0200, 1'b1);
    drive(32'h0001_0040, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("alias_old_miss", {31'b0, BTB_hit}, 32'd0);
    chk("alias_mis_count", mispredict_count, 32'd1);
    drive(32'h0001_0140, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("alias_new_hit", {31'b0, BTB_hit}, 32'd1);
    chk("alias_new_target", BTB_PC, 32'h0001_0200);
    chk("alias_new_pred", {31'b0, is_branch_predict}, 32'd1);

    // 5. Same-cycle lookup and allocate: no bypass
    drive(32'h0001_0080, 1'b1, 32'h0001_0080, 1'b1, 32'h0001_0300, 1'b1);
    chk("collide_miss", {31'b0, BTB_hit}, 32'd0);
    chk("collide_btb_pc", BTB_PC, 32'h0);
    drive(32'h0001_0080, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("collide_next_hit", {31'b0, BTB_hit}, 32'd1);
    chk("collide_next_target", BTB_PC, 32'h0001_0300);
    chk("collide_mis_count", mispredict_count, 32'd2);

    // 6. Counters: mispredict without update_valid is not counted
    drive(32'h0001_0080, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    chk("cnt_hits_a", hit_count, 32'd5);
    // not-taken miss must not allocate
    drive(IDLE, 1'b1, 32'h0001_0004, 1'b0, 32'h0001_0500, 1'b0);
    chk("cnt_hits_b", hit_count, 32'd6);
    chk("cnt_mis_b", mispredict_count, 32'd2);
    drive(32'h0001_0004, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("nt_no_alloc", {31'b0, BTB_hit}, 32'd0);

    // Mid-cycle reset with a hitting lookup and an update in flight
    drive(32'h0001_0080, 1'b1, 32'h0001_0080, 1'b1, 32'h0001_0600, 1'b1);
    chk("pre_rst_hit", {31'b0, BTB_hit}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("midrst_hit", {31'b0, BTB_hit}, 32'd0);
    chk("midrst_pred", {31'b0, is_branch_predict}, 32'd0);
    chk("midrst_btb_pc", BTB_PC, 32'h0);
    chk("midrst_hit_count", hit_count, 32'd0);
    chk("midrst_mis_count", mispredict_count, 32'd0);
    @(negedge clk);
    rst          = 1'b1;
    update_valid = 1'b0;
    #1;
    chk("postrst_first_miss", {31'b0, BTB_hit}, 32'd0);
    drive(32'h0001_0080, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("postrst_miss", {31'b0, BTB_hit}, 32'd0);
    chk("postrst_hit_count", hit_count, 32'd0);
    chk("postrst_mis_count", mispredict_count, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

- Direct-mapped branch target buffer (BTB) with a 2-bit saturating direction counter per entry.
- Sits beside the fetch stage. Fetch presents the current fetch PC on `lookup_PC`; this block returns, in the same cycle, whether that PC hits and whether the branch is predicted taken, plus the predicted target.
- Execute-stage branch resolution trains the table one cycle-registered write at a time.
- Also keeps free-running hit and mispredict counters for performance measurement.

## Interface
Parameters:
- `ENTRIES`, 64: number of BTB entries. Must be a power of two, 4 to 1024.
- `INDEX_W`, $clog2(ENTRIES): index width. Derived; never overridden.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `lookup_PC`  in  32  fetch PC to predict.
- `BTB_hit`  out  1  the entry for `lookup_PC` is valid and its tag matches.
- `is_branch_predict`  out  1  `BTB_hit` and the entry's counter bit[1] is set (predict taken).
- `BTB_PC`  out  32  stored target when `BTB_hit`; otherwise 32'h0.
- `update_valid`  in  1  a resolved branch or jump is presented this cycle.
- `update_PC`  in  32  PC of the resolved branch.
- `update_taken`  in  1  actual outcome.
- `update_target`  in  32  actual target; meaningful only when taken.
- `update_mispredict`  in  1  execute flagged a misprediction for this branch. Counted only; training uses `update_taken`.
- `hit_count`  out  32  number of cycles in which `BTB_hit` was 1.
- `mispredict_count`  out  32  number of cycles with `update_valid && update_mispredict`.

## Operation
- Address split: index = PC[INDEX_W+1:2], tag = PC[31:INDEX_W+2]. PC[1:0] is ignored.
- Per-entry state: valid bit, tag, 32-bit target, 2-bit counter. Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is purely combinational from `lookup_PC` and the stored state.
- Update rules, applied when `update_valid` is 1:
  - Entry valid and tag matches, `update_taken`=1: counter increments, saturating at 11; target is overwritten with `update_target`.
  - Entry valid and tag matches, `update_taken`=0: counter decrements, saturating at 00; target is left unchanged.
  - Entry invalid or tag mismatch, `update_taken`=1: allocate the entry (replacing any previous one): valid=1, tag and target written, counter=10.
  - Entry invalid or tag mismatch, `update_taken`=0: no change (not-taken branches are never allocated).
- Performance counters:
  - `hit_count` increments when `BTB_hit` is 1 at a clock edge.
  - `mispredict_count` increments when `update_valid && update_mispredict`.
  - Both wrap from 32'hFFFF_FFFF to 0.

## Timing
- Lookup latency is zero cycles, because fetch consumes these outputs at the same edge that advances `iaddr`.
- An update takes effect at the rising edge where `update_valid` is sampled. It is first visible to a lookup in the following cycle.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update contents. There is no write-through bypass.
- `update_valid` is sampled every cycle. There is no stall or handshake; one update per cycle is always accepted.
- Reset, asserted at any time including mid-update:
  - All valid bits clear, counters go to 01, targets and tags go to 0.
  - `hit_count` and `mispredict_count` go to 0.
  - Outputs go to `BTB_hit`=0, `is_branch_predict`=0, `BTB_PC`=0.
  - An update in flight during reset is discarded.
- On deassertion, the first lookup always misses.

## Structure
- Shared package `bp_pkg`:
  - counter encoding constants (`CTR_SNT`, `CTR_WNT`, `CTR_WT`, `CTR_ST`);
  - `CTR_ALLOC` (= `CTR_WT`);
  - pure function `ctr_next(ctr, taken)` implementing the saturating update;
  - `RESET_PC` 32'h0001_0000, shared with fetch.
- One sub-module, `btb_array`:
  - storage only: valid, tag, target and counter arrays;
  - one async-read port (the lookup index) and one sync-write port;
  - reset clears valid and counters.
- Top level `branch_predictor` does index/tag slicing, hit compare, allocate/train decisions, and the perf counters.

## Test plan
ENTRIES=64 for all cases.
1. **Reset.** Release reset, then drive `lookup_PC`=32'h0001_0000.
   - Required: `BTB_hit`=0, `is_branch_predict`=0, `BTB_PC`=0, both counters 0.
2. **Allocate.** Update with PC 32'h0001_0040, taken, target 32'h0001_0100.
   - Required, next cycle, lookup 32'h0001_0040: hit=1, predict=1, `BTB_PC`=32'h0001_0100.
3. **Saturate and train down.** Starting from case 2, apply two taken updates (counter 11), then two not-taken updates.
   - Required: counter 01, hit=1, predict=0, `BTB_PC` still 32'h0001_0100.
4. **Alias replace.** Update PC 32'h0001_0140 taken, target 32'h0001_0200. This has the same index 0x10 and a different tag.
   - Required: lookup 32'h0001_0040 gives hit=0; lookup 32'h0001_0140 gives hit=1 and `BTB_PC`=32'h0001_0200.
5. **Same-cycle collision.** Lookup and allocating update to 32'h0001_0080 in the same cycle.
   - Required: hit=0 that cycle, hit=1 the next cycle.
6. **Counters and mid-reset.** Drive 3 hit cycles and 2 mispredict updates.
   - Required: `hit_count`=3, `mispredict_count`=2.
   - Assert reset mid-cycle. Required: immediately 0 and no hits afterward.
